// File: rtl/joypad_ctrl_mp.sv
// joypad_ctrl_mp : NES-style joypad controller with 2-flop synchronizers,
// tick-sampled debounce, turbo A/B, opposing d-pad suppression and an
// optional Four Score multitap stream.
//
// Ports
//   i_clk        system clock (only clock in the block)
//   i_rstn       asynchronous active-low reset
//   i_jpd_vec    raw pad buttons, 10 bits per pad, 1 = pressed
//                [9]up [8]down [7]left [6]right [5]b [4]a
//                [3]turbo-b [2]turbo-a [1]select [0]start
//   i_bus_addr   CPU address
//   i_bus_cs     one-cycle access strobe; every cycle it is high is one access
//   i_bus_wn     0 = write, 1 = read
//   i_bus_wdata  write data (bit 0 = strobe at 0x4016)
//   o_jpd_rdata  combinational read data, {7'b0, serial bit}
//
// Bus handshake: there is no ready/stall. A cycle with i_bus_cs=1 is exactly
// one access; a read returns the current serial bit combinationally and the
// addressed port shifts at the end of that cycle.
module joypad_ctrl_mp #(
   parameter int NUM_PADS   = 2,
   parameter int FOUR_SCORE = 0,
   parameter int TURBO_W    = 16,
   parameter int DEB_W      = 4,
   parameter int MASK_OPP   = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [NUM_PADS*10-1:0]  i_jpd_vec,
   input  logic [15:0]             i_bus_addr,
   input  logic                    i_bus_cs,
   input  logic                    i_bus_wn,
   input  logic [7:0]              i_bus_wdata,
   output logic [7:0]              o_jpd_rdata
);

   localparam int   PW      = NUM_PADS * 10;
   localparam int   SW      = (FOUR_SCORE != 0) ? 24 : 8;
   localparam logic MASK_EN = (MASK_OPP != 0);

   // ---------------------------------------------------------------
   // Synchronizer, debounce and turbo counters
   // ---------------------------------------------------------------
   logic [PW-1:0]      sync1, sync2, samp, deb;
   logic [DEB_W-1:0]   tick_cnt;
   logic [TURBO_W-1:0] turbo_cnt;
   logic               tick;
   logic               phase;
   logic [PW-1:0]      agree;

   // Tick fires on the cycle the counter wraps from all-ones back to 0.
   assign tick  = &tick_cnt;
   assign phase = turbo_cnt[TURBO_W-1];
   // A bit may only move when this tick's sample matches the previous one.
   assign agree = ~(sync2 ^ samp);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sync1     <= '0;
         sync2     <= '0;
         samp      <= '0;
         deb       <= '0;
         tick_cnt  <= '0;
         turbo_cnt <= '0;
      end else begin
         sync1     <= i_jpd_vec;
         sync2     <= sync1;
         tick_cnt  <= tick_cnt + DEB_W'(1);
         turbo_cnt <= turbo_cnt + TURBO_W'(1);
         if (tick) begin
            samp <= sync2;
            deb  <= (deb & ~agree) | (sync2 & agree);
         end
      end
   end

   // ---------------------------------------------------------------
   // Per-pad report byte, LSB first: A B Select Start Up Down Left Right.
   // Pads beyond NUM_PADS report 0.
   // ---------------------------------------------------------------
   logic [7:0] pad_byte [4];

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_pad
         if (g < NUM_PADS) begin : g_on
            logic [9:0] raw;
            logic       up, dn, lf, rt, a_eff, b_eff;
            assign raw   = deb[10*g +: 10];
            assign up    = raw[9] & ~(MASK_EN & raw[8]);
            assign dn    = raw[8] & ~(MASK_EN & raw[9]);
            assign lf    = raw[7] & ~(MASK_EN & raw[6]);
            assign rt    = raw[6] & ~(MASK_EN & raw[7]);
            assign a_eff = raw[2] ? phase : raw[4];
            assign b_eff = raw[3] ? phase : raw[5];
            assign pad_byte[g] = {rt, lf, dn, up, raw[0], raw[1], b_eff, a_eff};
         end else begin : g_off
            assign pad_byte[g] = 8'h00;
         end
      end
   endgenerate

   // ---------------------------------------------------------------
   // Reload images for the two serial ports
   // ---------------------------------------------------------------
   logic [SW-1:0] load0, load1;

   generate
      if (FOUR_SCORE != 0) begin : g_fs
         // Signature bytes 0x08 / 0x04 follow the two pads of each port.
         assign load0 = {8'h08, pad_byte[2], pad_byte[0]};
         assign load1 = {8'h04, pad_byte[3], pad_byte[1]};
      end else begin : g_std
         assign load0 = pad_byte[0];
         assign load1 = pad_byte[1];
      end
   endgenerate

   logic unused_sig;
   assign unused_sig = ^{i_bus_wdata[7:1], pad_byte[2], pad_byte[3]};

   // ---------------------------------------------------------------
   // Bus decode, strobe and shift registers
   // ---------------------------------------------------------------
   logic          wr_strobe, rd0, rd1;
   logic          strobe;
   logic [SW-1:0] sr0, sr1;

   assign wr_strobe = i_bus_cs & ~i_bus_wn & (i_bus_addr == 16'h4016);
   assign rd0       = i_bus_cs &  i_bus_wn & (i_bus_addr == 16'h4016);
   assign rd1       = i_bus_cs &  i_bus_wn & (i_bus_addr == 16'h4017);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         strobe <= 1'b0;
         sr0    <= '0;
         sr1    <= '0;
      end else begin
         if (wr_strobe) begin
            strobe <= i_bus_wdata[0];
         end
         // The registered strobe is still 1 on the 1->0 write edge, so that
         // edge performs the final reload; shifting starts the cycle after.
         if (strobe) begin
            sr0 <= load0;
            sr1 <= load1;
         end else begin
            if (rd0) sr0 <= {1'b1, sr0[SW-1:1]};
            if (rd1) sr1 <= {1'b1, sr1[SW-1:1]};
         end
      end
   end

   always_comb begin
      o_jpd_rdata = 8'h00;
      if (rd0)      o_jpd_rdata = {7'b0, sr0[0]};
      else if (rd1) o_jpd_rdata = {7'b0, sr1[0]};
   end

endmodule

// File: tb/tb_joypad_ctrl_mp.sv
// Testbench for joypad_ctrl_mp: a standard 2-pad instance and a Four Score
// 4-pad instance share clock, reset and bus; each has its own pad inputs.
module tb_joypad_ctrl_mp;

   // ------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [19:0] jpd;
   logic [39:0] jpd4;
   logic [15:0] addr;
   logic        cs;
   logic        wn;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic [7:0]  rdata4;

   // Bit positions within a pad slice
   localparam int B_UP = 9, B_DOWN = 8, B_LEFT = 7, B_A = 4, B_B = 5;
   localparam int B_TA = 2, B_START = 0;

   joypad_ctrl_mp #(.NUM_PADS(2), .FOUR_SCORE(0), .TURBO_W(4), .DEB_W(4), .MASK_OPP(1)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_jpd_vec(jpd), .i_bus_addr(addr),
      .i_bus_cs(cs), .i_bus_wn(wn), .i_bus_wdata(wdata), .o_jpd_rdata(rdata));

   joypad_ctrl_mp #(.NUM_PADS(4), .FOUR_SCORE(1), .TURBO_W(4), .DEB_W(4), .MASK_OPP(1)) dut4 (
      .i_clk(clk), .i_rstn(rstn), .i_jpd_vec(jpd4), .i_bus_addr(addr),
      .i_bus_cs(cs), .i_bus_wn(wn), .i_bus_wdata(wdata), .o_jpd_rdata(rdata4));

   // ------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------
   logic [7:0] exp_q[$];
   logic [7:0] exp4_q[$];
   int checks   = 0;
   int failures = 0;

   // ------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d0, output logic [7:0] d4);
      @(negedge clk);
      addr = a; wn = 1'b1; cs = 1'b1;
      #1;
      d0 = rdata;
      d4 = rdata4;
      @(posedge clk);
      #1 cs = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wn = 1'b0; wdata = d; cs = 1'b1;
      @(posedge clk);
      #1 cs = 1'b0; wn = 1'b1;
   endtask

   task automatic do_strobe();
      bus_write(16'h4016, 8'h01);
      bus_write(16'h4016, 8'h00);
   endtask

   // Long enough for sync + two agreeing debounce ticks
   task automatic settle();
      wait_clk(60);
   endtask

   // ------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------
   task automatic test_reset();
      logic [7:0] d0, d4, e;
      @(negedge clk);
      addr = 16'h4016; wn = 1'b1; cs = 1'b0;
      #1;
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_idle_rdata got=%0h exp=00", rdata);
      end
      // Unstrobed reads after reset: zeros for the stream length, then ones
      for (int i = 1; i <= 25; i++) begin
         exp_q.push_back((i > 8) ? 8'h01 : 8'h00);
         exp4_q.push_back((i > 24) ? 8'h01 : 8'h00);
      end
      for (int i = 1; i <= 25; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL reset_stream read=%0d got=%0h exp=%0h", i, d0, e);
         end
         e = exp4_q.pop_front();
         checks++;
         if (d4 !== e) begin
            failures++;
            $display("FAIL reset_stream_fs read=%0d got=%0h exp=%0h", i, d4, e);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] d0, d4, e;
      logic [8:0] pat;
      jpd = '0;
      jpd[B_A] = 1'b1;
      jpd[B_START] = 1'b1;
      settle();
      do_strobe();
      pat = 9'b1_0000_1001;  // read order LSB first: A,B,Sel,Start,...,then 1
      for (int i = 0; i < 9; i++) exp_q.push_back({7'b0, pat[i]});
      for (int i = 1; i <= 9; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL basic_a_start read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
   endtask

   task automatic test_bus_decode();
      logic [7:0] d0, d4, e;
      logic [8:0] pat;
      // pad0 A+Start still held from the previous test
      bus_write(16'h4016, 8'h01);
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h01);
      for (int i = 1; i <= 3; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL strobe_read_no_shift read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      // cs low
      @(negedge clk);
      addr = 16'h4016; wn = 1'b1; cs = 1'b0;
      #1;
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL rdata_cs_low got=%0h exp=00", rdata);
      end
      // write cycle (keeps strobe at 1)
      @(negedge clk);
      addr = 16'h4016; wn = 1'b0; wdata = 8'h01; cs = 1'b1;
      #1;
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL rdata_on_write got=%0h exp=00", rdata);
      end
      @(posedge clk);
      #1 cs = 1'b0;
      // unmapped address
      @(negedge clk);
      addr = 16'h4018; wn = 1'b1; cs = 1'b1;
      #1;
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL rdata_bad_addr got=%0h exp=00", rdata);
      end
      @(posedge clk);
      #1 cs = 1'b0;
      bus_write(16'h4016, 8'h00);
      // Address parked without cs must not shift
      @(negedge clk);
      addr = 16'h4016; wn = 1'b1; cs = 1'b0;
      wait_clk(5);
      pat = 9'b1_0000_1001;
      for (int i = 0; i < 9; i++) exp_q.push_back({7'b0, pat[i]});
      for (int i = 1; i <= 9; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL held_addr_no_shift read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      // Strobe writes to 0x4017 are ignored: stream stays exhausted
      jpd = '0;
      settle();
      bus_write(16'h4017, 8'h01);
      wait_clk(2);
      bus_write(16'h4017, 8'h00);
      exp_q.push_back(8'h01);
      bus_read(16'h4016, d0, d4);
      e = exp_q.pop_front();
      checks++;
      if (d0 !== e) begin
         failures++;
         $display("FAIL write_4017_ignored got=%0h exp=%0h", d0, e);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] d0, d4, e;
      jpd = '0;
      settle();
      @(negedge clk);
      jpd[10 + B_B] = 1'b1;
      repeat (3) @(negedge clk);
      jpd[10 + B_B] = 1'b0;
      settle();
      do_strobe();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      for (int i = 1; i <= 2; i++) begin
         bus_read(16'h4017, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL glitch_rejected read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      // A steady press on the same bit must get through
      jpd[10 + B_B] = 1'b1;
      settle();
      do_strobe();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      for (int i = 1; i <= 2; i++) begin
         bus_read(16'h4017, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL pad1_b_held read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      jpd = '0;
   endtask

   task automatic test_turbo();
      logic [7:0] d0, d4, e;
      logic [7:0] v [40];
      int k;
      jpd = '0;
      jpd[B_TA] = 1'b1;
      settle();
      bus_write(16'h4016, 8'h01);
      // Reads under strobe return the live A bit without shifting
      for (int i = 0; i < 40; i++) begin
         bus_read(16'h4016, d0, d4);
         v[i] = d0;
      end
      bus_write(16'h4016, 8'h00);
      k = -1;
      for (int i = 2; i <= 10; i++) begin
         if (k < 0 && v[i] !== v[i-1]) k = i;
      end
      checks++;
      if (k < 0) begin
         failures++;
         $display("FAIL turbo_toggle got=no_edge exp=edge_within_9_clocks");
      end else begin
         for (int i = k; i < 40; i++)
            exp_q.push_back(v[k] ^ 8'(((i - k) / 8) % 2));
         for (int i = k; i < 40; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (v[i] !== e) begin
               failures++;
               $display("FAIL turbo_phase clk=%0d got=%0h exp=%0h", i, v[i], e);
            end
         end
      end
      jpd = '0;
   endtask

   task automatic test_mask();
      logic [7:0] d0, d4, e;
      logic [8:0] pat;
      jpd = '0;
      jpd[B_UP] = 1'b1;
      jpd[B_DOWN] = 1'b1;
      jpd[B_LEFT] = 1'b1;
      settle();
      do_strobe();
      pat = 9'b1_0100_0000;  // only Left survives
      for (int i = 0; i < 9; i++) exp_q.push_back({7'b0, pat[i]});
      for (int i = 1; i <= 9; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL mask_opp read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      jpd = '0;
   endtask

   task automatic test_four_score();
      logic [7:0] d0, d4, e;
      jpd4 = '0;
      settle();
      do_strobe();
      for (int i = 1; i <= 25; i++) exp4_q.push_back((i == 20 || i == 25) ? 8'h01 : 8'h00);
      for (int i = 1; i <= 25; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp4_q.pop_front();
         checks++;
         if (d4 !== e) begin
            failures++;
            $display("FAIL fs_4016_sig read=%0d got=%0h exp=%0h", i, d4, e);
         end
      end
      do_strobe();
      for (int i = 1; i <= 25; i++) exp4_q.push_back((i == 19 || i == 25) ? 8'h01 : 8'h00);
      for (int i = 1; i <= 25; i++) begin
         bus_read(16'h4017, d0, d4);
         e = exp4_q.pop_front();
         checks++;
         if (d4 !== e) begin
            failures++;
            $display("FAIL fs_4017_sig read=%0d got=%0h exp=%0h", i, d4, e);
         end
      end
      // pad2 A appears as the ninth bit of port 0x4016
      jpd4[20 + B_A] = 1'b1;
      settle();
      do_strobe();
      for (int i = 1; i <= 12; i++) exp4_q.push_back((i == 9) ? 8'h01 : 8'h00);
      for (int i = 1; i <= 12; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp4_q.pop_front();
         checks++;
         if (d4 !== e) begin
            failures++;
            $display("FAIL fs_pad2_a read=%0d got=%0h exp=%0h", i, d4, e);
         end
      end
      jpd4 = '0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d0, d4, e;
      jpd = '0;
      jpd[B_A] = 1'b1;
      jpd[B_START] = 1'b1;
      settle();
      do_strobe();
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      for (int i = 1; i <= 3; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL pre_reset read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
      jpd = '0;
      @(negedge clk);
      rstn = 1'b0;
      do_strobe();  // must have no effect while in reset
      exp_q.push_back(8'h00);
      bus_read(16'h4016, d0, d4);
      e = exp_q.pop_front();
      checks++;
      if (d0 !== e) begin
         failures++;
         $display("FAIL in_reset_read got=%0h exp=%0h", d0, e);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 1; i <= 9; i++) exp_q.push_back((i == 9) ? 8'h01 : 8'h00);
      for (int i = 1; i <= 9; i++) begin
         bus_read(16'h4016, d0, d4);
         e = exp_q.pop_front();
         checks++;
         if (d0 !== e) begin
            failures++;
            $display("FAIL post_reset read=%0d got=%0h exp=%0h", i, d0, e);
         end
      end
   endtask

   // ------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------
   initial begin
      rstn  = 1'b0;
      jpd   = '0;
      jpd4  = '0;
      addr  = 16'h0000;
      cs    = 1'b0;
      wn    = 1'b1;
      wdata = 8'h00;
      wait_clk(4);
      @(negedge clk);
      rstn = 1'b1;
      test_reset();
      test_basic();
      test_bus_decode();
      test_glitch();
      test_turbo();
      test_mask();
      test_four_score();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/joypad_ctrl_mp.md
JOYPAD_CTRL_MP -- requirements
Module: joypad_ctrl_mp

Interface
REQ-001 Parameter NUM_PADS, default 2, number of pads: 2 or 4 (4 only meaningful with FOUR_SCORE=1).
REQ-002 Parameter FOUR_SCORE, default 0, 1 = Four Score multitap mode with 24-bit serial stream per port.
REQ-003 Parameter TURBO_W, default 16, turbo counter width; turbo phase = counter MSB.
REQ-004 Parameter DEB_W, default 4, debounce sample interval = 2^DEB_W clocks.
REQ-005 Parameter MASK_OPP, default 1, 1 = suppress opposing d-pad directions.
REQ-006 i_clk  in  1  system clock; only clock in the block.
REQ-007 i_rstn  in  1  reset, asynchronous, active-low.
REQ-008 i_jpd_vec  in  NUM_PADS*10  raw pads, 1 = pressed; pad n at [10n+9:10n]; within a slice [9]up [8]down [7]left [6]right [5]b [4]a [3]turbo-b [2]turbo-a [1]select [0]start.
REQ-009 i_bus_addr  in  16  CPU address.
REQ-010 i_bus_cs  in  1  one-cycle access strobe; qualifies every bus action.
REQ-011 i_bus_wn  in  1  0 = write, 1 = read.
REQ-012 i_bus_wdata  in  8  write data.
REQ-013 o_jpd_rdata  out  8  read data, combinational.

Function
REQ-014 Raw inputs SHALL pass a 2-flop synchronizer per bit before any other use.
REQ-015 A free-running DEB_W-bit tick counter SHALL generate a sample tick on wrap; a debounced bit SHALL update only when two consecutive tick samples agree.
REQ-016 A free-running TURBO_W-bit counter SHALL wrap from all-ones to 0; effective A = turbo-a ? phase : a, same for B.
REQ-017 With MASK_OPP=1, up&down both set SHALL report both 0; left&right likewise.
REQ-018 Pad byte order SHALL be, LSB shifted first: A, B, Select, Start, Up, Down, Left, Right.
REQ-019 Write (cs, wn=0, addr 0x4016) SHALL set strobe = wdata[0]; addresses other than 0x4016 SHALL be ignored for writes.
REQ-020 While strobe=1, both port shift registers SHALL reload from debounced, turbo-applied, masked state every clock; reads SHALL NOT shift.
REQ-021 On the cycle strobe goes 1->0, the last reload SHALL be held; shifting mode begins next cycle.
REQ-022 FOUR_SCORE=0: port 0x4016 = pad0 (8 bits), port 0x4017 = pad1 (8 bits).
REQ-023 FOUR_SCORE=1: 0x4016 = pad0, pad2, signature 0x08 (bit 20 of stream = 1); 0x4017 = pad1, pad3, signature 0x04 (bit 19 = 1); missing pads (NUM_PADS=2) shift as 0.
REQ-024 Read (cs, wn=1, addr 0x4016/0x4017) SHALL return {7'b0, shift[0]} of that port and shift that port right by one at the clock edge, MSB filled with 1.
REQ-025 After the stream is exhausted (8 or 24 reads), reads SHALL return 1 indefinitely until next reload.
REQ-026 o_jpd_rdata SHALL be 0x00 when cs=0, wn=0, or address not 0x4016/0x4017.
REQ-027 A held address without cs SHALL NOT shift; exactly one shift per qualified read.

Reset
REQ-028 Reset SHALL clear synchronizers, debounced state, tick and turbo counters, strobe, and all shift registers to 0, asynchronously, including mid-stream.
REQ-029 After reset release, first reads without a strobe SHALL return 0 for the first 8/24 reads, then 1.

Verification
REQ-030 Pad0 A+Start held > 2*2^DEB_W clocks, write 0x4016=1 then 0, 8 reads of 0x4016 -> 1,0,0,1,0,0,0,0, ninth read -> 1.
REQ-031 Glitch on pad1 B for 3 clocks (< tick interval), strobe, read 0x4017 twice -> second read 0 (glitch rejected).
REQ-032 Pad0 turbo-a held, TURBO_W=4, strobe repeatedly -> A bit alternates every 8 clocks of strobe time.
REQ-033 MASK_OPP=1, pad0 up+down+left -> reads 5..8 give 0,0,1,0.
REQ-034 FOUR_SCORE=1, NUM_PADS=4, all pads idle, 24 reads of 0x4016 -> only read 20 = 1; 0x4017 -> only read 19 = 1.
REQ-035 Assert i_rstn low after 3 reads, release, read 0x4016 -> 0; strobe with idle pads during reset -> no state change.
